// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-sequencer: sequencing opcodes and
// the bit positions of the status flags inside the cond vector.
package micro_seq_pkg;

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JCC   = 3'd2,
    OP_JNC   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_LDCNT = 3'd6,
    OP_DJNZ  = 3'd7
  } seqOp_t;

  localparam int COND_Z = 0;
  localparam int COND_C = 1;
  localparam int COND_N = 2;
  localparam int COND_V = 3;

endpackage

// File: rtl/micro_sequencer_return_stack.sv
// Return-address LIFO for subroutine call/return. Storage is registered,
// the top-of-stack value is read combinationally so a return can use it
// in the same cycle it is decoded. Push into a full stack and pop from an
// empty stack are ignored here; the caller flags those as errors.
module return_stack #(
  parameter int ANCHO = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ANCHO-1:0]         i_pushData,
  input  logic                     i_pop,
  output logic [ANCHO-1:0]         o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ANCHO-1:0] r_mem [DEPTH];
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_wrIdx;
  logic [AW-1:0]    w_rdIdx;
  logic             w_doPush;
  logic             w_doPop;

  assign w_wrIdx  = r_count[AW-1:0];
  assign w_rdIdx  = w_wrIdx - AW'(1);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_top    = r_mem[w_rdIdx];
  assign o_count  = r_count;

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (rst && w_doPush) begin
      r_mem[w_wrIdx] <= i_pushData;
    end
  end

  // Occupancy counter: grows on push, shrinks on pop, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + (AW+1)'(1);
    end else if (w_doPop) begin
      r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-address decision unit for the microprogram counter. Decodes the
// sequencing opcode every cycle and tells the counter whether to increment
// or to load a new address. Owns the hardware loop counter and the sticky
// stack error flag; the return addresses live in return_stack.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ANCHO = 8,
  parameter int DEPTH = 4,
  parameter int LCW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ready,
  input  logic [2:0]             op,
  input  logic [1:0]             cond_sel,
  input  logic [3:0]             cond,
  input  logic [ANCHO-1:0]       branch_addr,
  input  logic [ANCHO-1:0]       cuenta,
  output logic                   ld_c,
  output logic [ANCHO-1:0]       load_addr,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   err
);

  logic [LCW-1:0]   r_loopCount;
  logic             r_err;
  logic [LCW-1:0]   w_loopMinus;
  logic             w_condBit;
  logic [ANCHO-1:0] w_retAddr;
  logic [ANCHO-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_errSet;
  logic             w_lcLoad;
  logic             w_lcDec;

  assign w_condBit   = cond[cond_sel];
  assign w_retAddr   = cuenta + ANCHO'(1);
  assign w_loopMinus = r_loopCount - LCW'(1);
  assign err         = r_err;

  return_stack #(
    .ANCHO(ANCHO),
    .DEPTH(DEPTH)
  ) uStack (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (w_retAddr),
    .i_pop      (w_pop),
    .o_top      (w_top),
    .o_count    (sp),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Opcode decode: counter control plus the state-update strobes.
  always_comb begin
    ld_c      = 1'b0;
    load_addr = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_errSet  = 1'b0;
    w_lcLoad  = 1'b0;
    w_lcDec   = 1'b0;
    if (rst) begin
      if (!ready) begin
        ld_c      = 1'b1;
        load_addr = cuenta;
      end else begin
        case (seqOp_t'(op))
          OP_CONT: begin
            ld_c = 1'b0;
          end
          OP_JMP: begin
            ld_c      = 1'b1;
            load_addr = branch_addr;
          end
          OP_JCC: begin
            if (w_condBit) begin
              ld_c      = 1'b1;
              load_addr = branch_addr;
            end
          end
          OP_JNC: begin
            if (!w_condBit) begin
              ld_c      = 1'b1;
              load_addr = branch_addr;
            end
          end
          OP_CALL: begin
            if (w_full) begin
              w_errSet = 1'b1;
            end else begin
              w_push    = 1'b1;
              ld_c      = 1'b1;
              load_addr = branch_addr;
            end
          end
          OP_RET: begin
            ld_c = 1'b1;
            if (w_empty) begin
              w_errSet = 1'b1;
            end else begin
              w_pop     = 1'b1;
              load_addr = w_top;
            end
          end
          OP_LDCNT: begin
            w_lcLoad = 1'b1;
          end
          OP_DJNZ: begin
            if (r_loopCount != '0) begin
              w_lcDec = 1'b1;
              if (w_loopMinus != '0) begin
                ld_c      = 1'b1;
                load_addr = branch_addr;
              end
            end
          end
          default: begin
            ld_c = 1'b0;
          end
        endcase
      end
    end
  end

  // Loop counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_loopCount <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_errSet) begin
        r_err <= 1'b1;
      end
      if (w_lcLoad) begin
        r_loopCount <= branch_addr[LCW-1:0];
      end else if (w_lcDec) begin
        r_loopCount <= w_loopMinus;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       ready;
  logic [2:0] op;
  logic [1:0] cond_sel;
  logic [3:0] cond;
  logic [7:0] branch_addr;
  logic [7:0] cuenta;
  logic       ld_c;
  logic [7:0] load_addr;
  logic [2:0] sp;
  logic       err;

  int vectorCount = 0;
  int missCount   = 0;

  micro_sequencer #(
    .ANCHO(8),
    .DEPTH(4),
    .LCW  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .op          (op),
    .cond_sel    (cond_sel),
    .cond        (cond),
    .branch_addr (branch_addr),
    .cuenta      (cuenta),
    .ld_c        (ld_c),
    .load_addr   (load_addr),
    .sp          (sp),
    .err         (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle's inputs just after a rising edge, then waits so
  // the combinational outputs have settled well before the next edge.
  task automatic applyStimulus(input logic rstN, input logic rdy,
                               input logic [2:0] o, input logic [1:0] cs,
                               input logic [3:0] c, input logic [7:0] ba,
                               input logic [7:0] cnt);
    @(posedge clk);
    #1;
    rst         = rstN;
    ready       = rdy;
    op          = o;
    cond_sel    = cs;
    cond        = c;
    branch_addr = ba;
    cuenta      = cnt;
    #2;
  endtask

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Counter control pair for the current cycle.
  task automatic checkLoad(input string tag, input logic expLd,
                           input logic [7:0] expAddr);
    checkOutput({tag, ".ld_c"}, 32'(ld_c), 32'(expLd));
    if (expLd) checkOutput({tag, ".load_addr"}, 32'(load_addr), 32'(expAddr));
  endtask

  task automatic checkState(input string tag, input logic [2:0] expSp,
                            input logic expErr);
    checkOutput({tag, ".sp"}, 32'(sp), 32'(expSp));
    checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b1, OP_JMP, 2'd0, 4'h0, 8'h55, 8'h12);
    checkOutput("rst.ld_c", 32'(ld_c), 32'h0);
    checkOutput("rst.load_addr", 32'(load_addr), 32'h0);
    applyStimulus(1'b0, 1'b1, OP_CALL, 2'd0, 4'h0, 8'h55, 8'h12);
    checkOutput("rst2.ld_c", 32'(ld_c), 32'h0);
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; op = OP_CONT; cond_sel = 2'd0;
    cond = 4'h0; branch_addr = 8'h00; cuenta = 8'h00;
    $display("[TB] starting micro_sequencer bench");

    resetDut();

    // Continue after reset
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h05);
    checkLoad("cont", 1'b0, 8'h00);
    checkState("cont", 3'd0, 1'b0);
    checkOutput("cont.lc", 32'(dut.r_loopCount), 32'h0);

    // Conditional branches
    applyStimulus(1'b1, 1'b1, OP_JCC, COND_Z, 4'b0001, 8'h40, 8'h06);
    checkLoad("jccTaken", 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b1, OP_JCC, COND_Z, 4'b0000, 8'h40, 8'h07);
    checkLoad("jccNot", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_JNC, COND_Z, 4'b0000, 8'h40, 8'h08);
    checkLoad("jncTaken", 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b1, OP_JNC, COND_Z, 4'b0001, 8'h40, 8'h09);
    checkLoad("jncNot", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_JCC, COND_N, 4'b0100, 8'h4C, 8'h0A);
    checkLoad("jccN", 1'b1, 8'h4C);
    applyStimulus(1'b1, 1'b1, OP_JCC, COND_V, 4'b0111, 8'h4D, 8'h0B);
    checkLoad("jccVclr", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_JMP, 2'd0, 4'h0, 8'h3E, 8'h0C);
    checkLoad("jmp", 1'b1, 8'h3E);

    // Call then immediate return
    applyStimulus(1'b1, 1'b1, OP_CALL, 2'd0, 4'h0, 8'h80, 8'h10);
    checkLoad("call", 1'b1, 8'h80);
    checkState("call", 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_RET, 2'd0, 4'h0, 8'h00, 8'h80);
    checkLoad("ret", 1'b1, 8'h11);
    checkState("ret", 3'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h11);
    checkState("afterRet", 3'd0, 1'b0);

    // Hold with ready low, then the call proceeds
    applyStimulus(1'b1, 1'b0, OP_CALL, 2'd0, 4'h0, 8'h90, 8'h33);
    checkLoad("hold", 1'b1, 8'h33);
    applyStimulus(1'b1, 1'b1, OP_CALL, 2'd0, 4'h0, 8'h90, 8'h33);
    checkOutput("hold.sp", 32'(sp), 32'h0);
    checkLoad("holdRelease", 1'b1, 8'h90);
    applyStimulus(1'b1, 1'b1, OP_RET, 2'd0, 4'h0, 8'h00, 8'h90);
    checkOutput("holdPush.sp", 32'(sp), 32'h1);
    checkLoad("holdRet", 1'b1, 8'h34);

    // Return address wraps past the top of the address space
    applyStimulus(1'b1, 1'b1, OP_CALL, 2'd0, 4'h0, 8'h10, 8'hFF);
    checkLoad("wrapCall", 1'b1, 8'h10);
    applyStimulus(1'b1, 1'b1, OP_RET, 2'd0, 4'h0, 8'h00, 8'h10);
    checkLoad("wrapRet", 1'b1, 8'h00);
    checkState("wrapRet", 3'd1, 1'b0);

    // Fill the stack, then overflow it
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, OP_CALL, 2'd0, 4'h0, 8'hA0, 8'(i));
      checkLoad("fill", 1'b1, 8'hA0);
    end
    applyStimulus(1'b1, 1'b1, OP_CALL, 2'd0, 4'h0, 8'hA0, 8'h05);
    checkLoad("overflow", 1'b0, 8'h00);
    checkState("overflow", 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, OP_RET, 2'd0, 4'h0, 8'h00, 8'hA0);
      checkOutput("drain.sp", 32'(sp), 32'(4 - i));
      checkLoad("drain", 1'b1, 8'(5 - i));
    end
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h00);
    checkState("drained", 3'd0, 1'b1);

    // Reset clears the error; underflow sets it again
    resetDut();
    applyStimulus(1'b1, 1'b1, OP_RET, 2'd0, 4'h0, 8'h77, 8'h21);
    checkLoad("underflow", 1'b1, 8'h00);
    checkState("underflow", 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h00);
    checkState("afterUnderflow", 3'd0, 1'b1);
    applyStimulus(1'b1, 1'b1, OP_JMP, 2'd0, 4'h0, 8'h01, 8'h01);
    checkOutput("sticky.err", 32'(err), 32'h1);

    // A call under reset is discarded
    resetDut();
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h00);
    checkState("rstCall", 3'd0, 1'b0);

    // Hardware loop
    applyStimulus(1'b1, 1'b1, OP_LDCNT, 2'd0, 4'h0, 8'h03, 8'h1F);
    checkLoad("ldcnt", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_DJNZ, 2'd0, 4'h0, 8'h20, 8'h20);
    checkOutput("ldcnt.lc", 32'(dut.r_loopCount), 32'h3);
    checkLoad("djnz1", 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b1, OP_DJNZ, 2'd0, 4'h0, 8'h20, 8'h21);
    checkLoad("djnz2", 1'b1, 8'h20);
    applyStimulus(1'b1, 1'b1, OP_DJNZ, 2'd0, 4'h0, 8'h20, 8'h21);
    checkLoad("djnz3", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_DJNZ, 2'd0, 4'h0, 8'h20, 8'h22);
    checkOutput("djnz3.lc", 32'(dut.r_loopCount), 32'h0);
    checkLoad("djnz4", 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, OP_CONT, 2'd0, 4'h0, 8'h00, 8'h23);
    checkOutput("djnz4.lc", 32'(dut.r_loopCount), 32'h0);
    checkState("loopEnd", 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address decision unit for the microprogrammed machine. Sits beside the microprogram counter and drives its load control and parallel-load address. Inputs are the current microinstruction's sequencing fields, the status flags and the counter's present value. Adds conditional branches, subroutine call/return through a small return-address stack, a hardware loop counter and a wait-for-ready hold.

## Interface
- ANCHO, 8: microprogram address width; must match the counter.
- DEPTH, 4: return-stack entries (power of two, ≥2).
- LCW, 8: loop-counter width (LCW ≤ ANCHO).

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ready  in  1  datapath/memory ready; 0 = hold current microinstruction
- op  in  3  sequencing opcode of current microinstruction
- cond_sel  in  2  selects one bit of cond
- cond  in  4  status flags (Z, C, N, V order = bits 0..3)
- branch_addr  in  ANCHO  target address / loop-count immediate
- cuenta  in  ANCHO  current counter value
- ld_c  out  1  1 = counter loads load_addr; 0 = counter increments
- load_addr  out  ANCHO  parallel-load value for counter
- sp  out  log2(DEPTH)+1  stack occupancy, 0..DEPTH
- err  out  1  sticky stack overflow/underflow flag

## Operation
- ld_c and load_addr are combinational from inputs and registered state. Stack, sp, loop counter lc and err update on posedge clk.
- ready=0: ld_c=1, load_addr=cuenta (hold), regardless of op. No state change.
- ready=1, ops:
  - 0 CONT: ld_c=0.
  - 1 JMP: load branch_addr.
  - 2 JCC: load branch_addr if cond[cond_sel]=1, else ld_c=0.
  - 3 JNC: load branch_addr if cond[cond_sel]=0, else ld_c=0.
  - 4 CALL: push cuenta+1 (mod 2^ANCHO), sp+1, load branch_addr.
  - 5 RET: pop, sp−1, load popped value.
  - 6 LDCNT: lc ← branch_addr[LCW-1:0], ld_c=0.
  - 7 DJNZ: if lc≠0, lc ← lc−1; then load branch_addr if new lc≠0, else ld_c=0. If lc=0 already, no decrement, ld_c=0.
- Boundaries:
  - CALL with sp=DEPTH: no push, sp unchanged, ld_c=0 (falls through), err←1.
  - RET with sp=0: load_addr=0, ld_c=1 (restart at 0), sp stays 0, err←1.
  - err is cleared only by reset.
  - cond_sel/cond/op values are only sampled when ready=1.

## Timing
- Zero-latency decision: outputs valid in the same cycle as op. The counter takes effect at the next posedge.
- Stack write, sp, lc and err take effect at that same posedge, so a RET in the cycle right after a CALL returns the just-pushed address.
- Reset (rst=0 at posedge): sp=0, lc=0, err=0, stack contents don't-care.
- While rst=0, outputs are forced: ld_c=0, load_addr=0.
- Reset mid-CALL/RET discards the operation.

## Structure
- Shared package micro_seq_pkg holds the op encodings (OP_CONT..OP_DJNZ) and the cond bit indices (COND_Z, COND_C, COND_N, COND_V).
- One sub-module, return_stack:
  - parameterised LIFO (ANCHO, DEPTH) with push/pop/top/count/full/empty;
  - registered storage, combinational top.
- micro_sequencer holds the opcode decode, lc and err.

## Test plan
- Reset, then CONT with cuenta=0x05, ready=1 -> ld_c=0; sp=0, err=0, lc=0.
- JCC cond_sel=0, cond=0001, branch_addr=0x40 -> ld_c=1, load_addr=0x40. Same with cond=0000 -> ld_c=0. JNC gives the inverse.
- CALL with cuenta=0x10 and branch_addr=0x80, then RET next cycle -> first cycle load_addr=0x80, sp=1; second cycle load_addr=0x11, sp=0.
- Overflow: 4 CALLs, then a 5th CALL -> ld_c=0, sp=4, err=1. RET on empty stack after reset -> load_addr=0x00, ld_c=1, err=1.
- Loop: LDCNT 0x03, then DJNZ to 0x20 three times -> loads 0x20, 0x20, then ld_c=0 with lc=0. A further DJNZ -> ld_c=0, lc stays 0.
- ready=0 during CALL with cuenta=0x33 -> ld_c=1, load_addr=0x33, sp unchanged. Raising ready -> push occurs. Wraparound CALL at cuenta=0xFF -> pushed return address 0x00.
